// File: rtl/shift_register_display.sv
// Button-loaded WIDTH x DEPTH register chain with shift/rotate/clear/hold modes,
// occupancy tracking and a time-multiplexed 8-digit hex display of the valid stages.
module shift_register_display #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(DEPTH+1),
  localparam int SCW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic             CLOCK_50_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             nload_i,
  output logic [WIDTH-1:0] out_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic [7:0]       an_o,
  output logic             ca_o,
  output logic             cb_o,
  output logic             cc_o,
  output logic             cd_o,
  output logic             ce_o,
  output logic             cf_o,
  output logic             cg_o
);

  localparam logic [1:0] M_SHIFT  = 2'b00;
  localparam logic [1:0] M_ROTATE = 2'b01;
  localparam logic [1:0] M_CLEAR  = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  logic [SYNC_STAGES-1:0]            r_nload_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0][1:0]       r_mode_sync;
  logic                              r_prev;
  logic [SYNC_STAGES:0]              r_fill;
  logic                              w_load;
  logic [WIDTH-1:0]                  w_data;
  logic [1:0]                        w_mode;

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [CW-1:0]               r_count;
  logic                        w_full;

  logic [SCW-1:0] r_scan_cnt;
  logic [2:0]     r_digit;
  logic           w_digit_on;
  logic [3:0]     w_hex;
  logic [6:0]     w_seg;
  logic [7:0]     r_an;
  logic [6:0]     r_seg;

  // r_fill blanks the edge detector until the synchronisers and r_prev hold
  // real post-reset samples, so a button held through reset does not load.
  always_ff @(posedge CLOCK_50_i) begin
    if (rst_i) begin
      r_nload_sync <= '1;
      r_data_sync  <= '0;
      r_mode_sync  <= '0;
      r_prev       <= 1'b1;
      r_fill       <= '0;
    end else begin
      r_nload_sync <= {r_nload_sync[SYNC_STAGES-2:0], nload_i};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], data_i};
      r_mode_sync  <= {r_mode_sync[SYNC_STAGES-2:0], mode_i};
      r_prev       <= r_nload_sync[SYNC_STAGES-1];
      r_fill       <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_load = r_prev & ~r_nload_sync[SYNC_STAGES-1] & r_fill[SYNC_STAGES];
  assign w_data = r_data_sync[SYNC_STAGES-1];
  assign w_mode = r_mode_sync[SYNC_STAGES-1];
  assign w_full = (r_count == CW'(DEPTH));

  always_ff @(posedge CLOCK_50_i) begin
    if (rst_i) begin
      r_stage <= '0;
      r_count <= '0;
    end else if (w_load) begin
      case (w_mode)
        M_SHIFT: begin
          r_stage <= {r_stage[DEPTH-2:0], w_data};
          if (!w_full) r_count <= r_count + CW'(1);
        end
        M_ROTATE: r_stage <= {r_stage[DEPTH-2:0], r_stage[DEPTH-1]};
        M_CLEAR: begin
          r_stage <= '0;
          r_count <= '0;
        end
        M_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_i) begin
    if (rst_i) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCW'(SCAN_DIV-1)) begin
      r_scan_cnt <= '0;
      r_digit    <= (r_digit == 3'(DEPTH-1)) ? 3'd0 : r_digit + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCW'(1);
    end
  end

  assign w_digit_on = (int'(r_digit) < int'(r_count));
  assign w_hex      = 4'(r_stage[r_digit]);

  always_comb begin
    w_seg = 7'b1111111;
    case (w_hex)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge CLOCK_50_i) begin
    if (rst_i) begin
      r_an  <= 8'hFF;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_digit_on ? ~(8'b1 << r_digit) : 8'hFF;
      r_seg <= w_digit_on ? w_seg : 7'b1111111;
    end
  end

  assign out_o   = r_stage[DEPTH-1];
  assign count_o = r_count;
  assign full_o  = w_full;
  assign an_o    = r_an;
  assign {ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o} = r_seg;

endmodule
